tc_fetch_queue: RTL and testbench
=================================

// Module: tc_fetch_queue
// PURPOSE
//  Instruction fetch stage placed directly downstream of the program-word ROM (4 words per lookup, combinational read).
//  Drives the ROM address, captures out0..out3 as one 4-word block into a circular queue, and hands words one at a time to the decoder.
//  The decoder side uses a valid/ready handshake.
//  A jump flushes the queue and restarts fetch at a new program address.
// PARAMETERS
//  BIT_WIDTH  16  width of one program word (8..64)
//  DEPTH      8   queue entries; power of 2, >= 4
// PORTS
//  clk          in   1          clock; all state updates on rising edge
//  rst          in   1          reset, synchronous, active-low (rst==0 resets on clk edge)
//  mem_address  out  16         address to program ROM; registered copy of fetch_pc
//  mem_out0..3  in   BIT_WIDTH  ROM words at mem_address+0..+3, valid same cycle
//  fetch_en     in   1          1 = block fetch allowed this cycle
//  jump         in   1          redirect request, single-cycle pulse
//  jump_target  in   16         new fetch address, sampled when jump==1
//  instr_valid  out  1          head entry present (count!=0)
//  instr_ready  in   1          decoder accepts head this cycle
//  instr        out  BIT_WIDTH  head word; 0 when queue empty
//  instr_pc     out  16         program address of head word; 0 when empty
//  count        out  clog2(DEPTH+1)  occupied entries
// BEHAVIOUR
//  Reset (rst==0 at edge): fetch_pc=0, wr_ptr=rd_ptr=0, count=0.
//   Outputs after reset: mem_address=0, instr_valid=0, instr=0, instr_pc=0.
//   Queue contents are don't-care.
//  State: RUN only after reset. No other FSM states; behaviour is defined by the per-cycle priority below.
//  Per cycle:
//   pop  = instr_valid & instr_ready
//   push = fetch_en & (DEPTH - count >= 4)
//   push uses count BEFORE this cycle's pop; no same-cycle credit.
//  push: write mem_out0..3 with pcs fetch_pc+0..+3 into entries wr_ptr..wr_ptr+3 (mod DEPTH); wr_ptr+=4; fetch_pc+=4.
//  pop: rd_ptr+=1.
//  count_next = count + 4*push - pop.
//   Simultaneous push and pop are both applied.
//  jump==1 (priority over push):
//   - A same-cycle pop is a completed transfer.
//   - Any same-cycle push is discarded.
//   - Next: count=0, rd_ptr=wr_ptr=0, fetch_pc=jump_target.
//  Latency: jump or reset at edge N -> mem_address=target at N.
//   Block written at edge N+1 (if fetch_en=1) -> instr_valid=1 after N+1.
//   First instruction is therefore visible 1 cycle after the redirect.
//  Throughput: with instr_ready=1 and fetch_en=1, sustains 1 word/cycle after first fill.
//  Pointer and address arithmetic:
//   - Pointers wrap modulo DEPTH.
//   - fetch_pc and stored pcs wrap modulo 2^16 (0xFFFE+2 -> 0x0000).
//  Full: count>DEPTH-4 -> no push; mem_address holds.
//  Empty: instr_valid=0, instr/instr_pc forced 0; instr_ready ignored, no underflow.
//  fetch_en=0: no push, mem_address holds, pops continue.
//  instr and instr_pc are combinational from the head entry; stable while valid & ~ready.
//  Handshake rule: once instr_valid=1, head stays unchanged until popped or jump.
//  Reset mid-operation: all above reset values at next edge; in-flight words lost; jump ignored in a reset cycle.
// TESTING
//  1. ROM word[a]=0x1000+a, ready=1, fetch_en=1, release reset
//     -> instr 0x1000,0x1001,0x1002... one per cycle from cycle 2; instr_pc 0,1,2; never a bubble.
//  2. ready=0 from reset -> count 4 then 8; mem_address stops at 0x0008.
//     Then ready=1 for 1 cycle -> count 7, no push; next cycle count 6.
//  3. Queue holding 6, jump=1 to 0x0040 with ready=1
//     -> head accepted, next cycle count=0, valid=0.
//     Following cycle instr_pc=0x0040, instr=0x1040.
//  4. jump to 0xFFFE -> instr_pc sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001; mem_address 0xFFFE then 0x0002.
//  5. rst=0 for one cycle while count=5
//     -> next cycle count=0, valid=0, mem_address=0, instr=0; refill restarts at pc 0.
//  6. fetch_en=0 with count=3, ready=1 -> three pops, then valid=0, instr=0; mem_address unchanged throughout.

Source files
------------

// File: rtl/tc_fetch_queue.sv
// ============================================================================
//  tc_fetch_queue : 4-word block fetch from program ROM into a circular queue,
//                   handing words one at a time to the decoder (valid/ready).
//  Revision 1.0
// ============================================================================
`default_nettype none

module tc_fetch_queue #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned DEPTH     = 8,
  localparam int unsigned CW       = $clog2(DEPTH + 1),
  localparam int unsigned PW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [15:0]          mem_address,
  input  logic [BIT_WIDTH-1:0] mem_out0,
  input  logic [BIT_WIDTH-1:0] mem_out1,
  input  logic [BIT_WIDTH-1:0] mem_out2,
  input  logic [BIT_WIDTH-1:0] mem_out3,
  input  logic                 fetch_en,
  input  logic                 jump,
  input  logic [15:0]          jump_target,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [BIT_WIDTH-1:0] instr,
  output logic [15:0]          instr_pc,
  output logic [CW-1:0]        count
);

  logic [15:0]          fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [BIT_WIDTH-1:0] word_q [DEPTH];
  logic [15:0]          pc_q   [DEPTH];

  logic [BIT_WIDTH-1:0] blk_words [4];
  logic [CW:0]          free_slots;
  logic                 push, pop, wr_en;

  assign blk_words[0] = mem_out0;
  assign blk_words[1] = mem_out1;
  assign blk_words[2] = mem_out2;
  assign blk_words[3] = mem_out3;

  // Push decision uses occupancy before this cycle's pop.
  assign free_slots = (CW + 1)'(DEPTH) - {1'b0, count_q};
  assign push       = fetch_en & (free_slots >= (CW + 1)'(4));
  assign pop        = instr_valid & instr_ready;
  assign wr_en      = push & ~jump & rst;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (jump) begin
      fetch_pc_d = jump_target;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 16'd4;
        wr_ptr_d   = wr_ptr_q + PW'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + (push ? CW'(4) : CW'(0)) - (pop ? CW'(1) : CW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        word_q[wr_ptr_q + PW'(k)] <= blk_words[k];
        pc_q[wr_ptr_q + PW'(k)]   <= fetch_pc_q + 16'(k);
      end
    end
  end

  assign mem_address = fetch_pc_q;
  assign count       = count_q;
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? word_q[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? pc_q[rd_ptr_q]   : '0;

endmodule

`default_nettype wire

// File: tb/tb_tc_fetch_queue.sv
// ============================================================================
//  tb_tc_fetch_queue : directed self-checking bench for tc_fetch_queue.
//  Revision 1.0
// ============================================================================
`default_nettype none

module tb_tc_fetch_queue;

  logic        clk;
  logic        rst;
  logic [15:0] mem_address;
  logic [15:0] mem_out0, mem_out1, mem_out2, mem_out3;
  logic        fetch_en;
  logic        jump;
  logic [15:0] jump_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [3:0]  count;

  int total = 0;
  int bad   = 0;

  tc_fetch_queue #(.BIT_WIDTH(16), .DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_address (mem_address),
    .mem_out0    (mem_out0),
    .mem_out1    (mem_out1),
    .mem_out2    (mem_out2),
    .mem_out3    (mem_out3),
    .fetch_en    (fetch_en),
    .jump        (jump),
    .jump_target (jump_target),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: word[a] = 0x1000 + a, modulo 2^16.
  always_comb begin
    mem_out0 = 16'h1000 + mem_address;
    mem_out1 = 16'h1000 + mem_address + 16'd1;
    mem_out2 = 16'h1000 + mem_address + 16'd2;
    mem_out3 = 16'h1000 + mem_address + 16'd3;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst         = 1'b0;
    fetch_en    = 1'b1;
    jump        = 1'b0;
    jump_target = 16'h0000;
    instr_ready = 1'b1;

    // Reset state
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_pc",    32'(instr_pc), 32'd0);
    chk("rst_addr",  32'(mem_address), 32'd0);

    // 1: streaming, one word per cycle with no bubble
    rst = 1'b1;
    tick();
    chk("s1_first_valid", 32'(instr_valid), 32'd1);
    chk("s1_first_instr", 32'(instr), 32'h1000);
    chk("s1_first_addr",  32'(mem_address), 32'h0004);
    for (int i = 1; i < 12; i++) begin
      tick();
      chk("s1_valid", 32'(instr_valid), 32'd1);
      chk("s1_instr", 32'(instr), 32'h1000 + 32'(i));
      chk("s1_pc",    32'(instr_pc), 32'(i));
    end

    // 2: decoder stalled -> fills to 8, address stops at 8
    instr_ready = 1'b0;
    do_reset();
    tick();
    chk("s2_cnt4",  32'(count), 32'd4);
    chk("s2_addr4", 32'(mem_address), 32'h0004);
    tick();
    chk("s2_cnt8",  32'(count), 32'd8);
    chk("s2_addr8", 32'(mem_address), 32'h0008);
    tick();
    chk("s2_full_cnt",   32'(count), 32'd8);
    chk("s2_full_addr",  32'(mem_address), 32'h0008);
    chk("s2_hold_instr", 32'(instr), 32'h1000);
    instr_ready = 1'b1;
    tick();
    chk("s2_cnt7",  32'(count), 32'd7);
    chk("s2_addr7", 32'(mem_address), 32'h0008);
    chk("s2_pc1",   32'(instr_pc), 32'd1);
    tick();
    chk("s2_cnt6",  32'(count), 32'd6);

    // 3: jump with queue holding 6 and ready=1
    jump        = 1'b1;
    jump_target = 16'h0040;
    tick();
    jump = 1'b0;
    chk("s3_cnt0",  32'(count), 32'd0);
    chk("s3_valid", 32'(instr_valid), 32'd0);
    chk("s3_instr0", 32'(instr), 32'd0);
    chk("s3_addr",  32'(mem_address), 32'h0040);
    tick();
    chk("s3_pc",    32'(instr_pc), 32'h0040);
    chk("s3_instr", 32'(instr), 32'h1040);
    tick();
    chk("s3_pc_next", 32'(instr_pc), 32'h0041);

    // 4: jump near top of address space, wrap modulo 2^16
    jump        = 1'b1;
    jump_target = 16'hFFFE;
    tick();
    jump = 1'b0;
    chk("s4_addr_tgt", 32'(mem_address), 32'hFFFE);
    chk("s4_valid0",   32'(instr_valid), 32'd0);
    tick();
    chk("s4_pc0",   32'(instr_pc), 32'hFFFE);
    chk("s4_ins0",  32'(instr), 32'h0FFE);
    chk("s4_addr2", 32'(mem_address), 32'h0002);
    tick();
    chk("s4_pc1",   32'(instr_pc), 32'hFFFF);
    tick();
    chk("s4_pc2",   32'(instr_pc), 32'h0000);
    chk("s4_ins2",  32'(instr), 32'h1000);
    tick();
    chk("s4_pc3",   32'(instr_pc), 32'h0001);

    // 5: reset mid-operation while count=5
    instr_ready = 1'b0;
    do_reset();
    tick();
    tick();
    instr_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("s5_cnt5", 32'(count), 32'd5);
    rst = 1'b0;
    jump        = 1'b1;
    jump_target = 16'h0123;
    tick();
    rst  = 1'b1;
    jump = 1'b0;
    chk("s5_cnt0",  32'(count), 32'd0);
    chk("s5_valid", 32'(instr_valid), 32'd0);
    chk("s5_addr",  32'(mem_address), 32'd0);
    chk("s5_instr", 32'(instr), 32'd0);
    tick();
    chk("s5_refill_cnt", 32'(count), 32'd4);
    chk("s5_refill_pc",  32'(instr_pc), 32'd0);
    chk("s5_refill_ins", 32'(instr), 32'h1000);

    // 6: fetch disabled, drain to empty, address held
    fetch_en = 1'b0;
    tick();
    chk("s6_cnt3",  32'(count), 32'd3);
    chk("s6_addr3", 32'(mem_address), 32'h0004);
    chk("s6_pc1",   32'(instr_pc), 32'd1);
    tick();
    chk("s6_cnt2",  32'(count), 32'd2);
    tick();
    chk("s6_cnt1",  32'(count), 32'd1);
    chk("s6_pc3",   32'(instr_pc), 32'd3);
    tick();
    chk("s6_cnt0",   32'(count), 32'd0);
    chk("s6_valid",  32'(instr_valid), 32'd0);
    chk("s6_instr",  32'(instr), 32'd0);
    chk("s6_addr0",  32'(mem_address), 32'h0004);
    tick();
    chk("s6_no_underflow", 32'(count), 32'd0);
    chk("s6_addr_hold",    32'(mem_address), 32'h0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
